fwd_hazard_scoreboard: RTL and testbench

//  Parametrised forwarding and load-use hazard unit for the rv32i pipeline.

---
 rtl/fwd_hazard_scoreboard_if.sv | 32 +++
 rtl/fwd_hazard_scoreboard.sv | 101 ++++++++++
 tb/tb_fwd_hazard_scoreboard.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_scoreboard_if.sv
// ID-stage hazard query bus: instruction/pipeline-control inputs and the
// forwarding selects, stall and stall counter returned by the scoreboard.
interface fwd_hazard_scoreboard_if #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned CNT_W   = 32
);
  localparam int unsigned SELW = $clog2(DEPTH + 1);

  logic                      id_valid;
  logic [5*NUM_SRC-1:0]      id_rs;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic [4:0]                id_rd;
  logic                      id_we;
  logic                      id_is_load;
  logic                      advance;
  logic                      flush;
  logic                      stall;
  logic [SELW*NUM_SRC-1:0]   fwd_sel;
  logic [NUM_SRC-1:0]        fwd_mem;
  logic [CNT_W-1:0]          stall_count;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rd, id_we, id_is_load, advance, flush,
    input  stall, fwd_sel, fwd_mem, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rd, id_we, id_is_load, advance, flush,
    output stall, fwd_sel, fwd_mem, stall_count
  );
endinterface

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding / load-use hazard unit: shadows DEPTH in-flight writers after ID and
// picks the youngest matching producer per source operand, stalling on unready loads.
module fwd_hazard_scoreboard #(
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  fwd_hazard_scoreboard_if.slave bus
);
  localparam int unsigned SELW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       is_load;
  } entry_t;

  entry_t [DEPTH-1:0]      entry_q, entry_d;
  logic   [CNT_W-1:0]      stall_count_q, stall_count_d;

  logic                    stall;
  logic [NUM_SRC-1:0]      hazard;
  logic [NUM_SRC-1:0]      found;
  logic [NUM_SRC-1:0]      win_load;
  int unsigned             win_k [NUM_SRC];
  logic [SELW*NUM_SRC-1:0] fwd_sel;
  logic [NUM_SRC-1:0]      fwd_mem;

  // Youngest match is taken first; an unready load therefore blocks any older
  // non-load match from being forwarded instead.
  always_comb begin
    hazard   = '0;
    found    = '0;
    win_load = '0;
    fwd_sel  = '0;
    fwd_mem  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      win_k[i] = 0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (!found[i] && bus.id_valid && bus.id_rs_used[i] &&
            (bus.id_rs[5*i +: 5] != 5'd0) && entry_q[k].valid && entry_q[k].we &&
            (entry_q[k].rd == bus.id_rs[5*i +: 5])) begin
          found[i]    = 1'b1;
          win_k[i]    = k;
          win_load[i] = entry_q[k].is_load;
        end
      end
      hazard[i] = found[i] && win_load[i] && (win_k[i] < LOAD_LAT);
      if (found[i] && !hazard[i]) begin
        fwd_sel[SELW*i +: SELW] = SELW'(win_k[i] + 1);
        fwd_mem[i]              = win_load[i];
      end
    end
    stall = |hazard;
  end

  always_comb begin
    entry_d = entry_q;
    if (bus.flush) begin
      entry_d = '0;
    end else if (bus.advance) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        entry_d[k] = entry_q[k-1];
      end
      if (bus.id_valid && !stall) begin
        entry_d[0].valid   = 1'b1;
        entry_d[0].rd      = bus.id_rd;
        entry_d[0].we      = bus.id_we && (bus.id_rd != 5'd0);
        entry_d[0].is_load = bus.id_is_load;
      end else begin
        entry_d[0] = '0;
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q       <= '0;
      stall_count_q <= '0;
    end else begin
      entry_q       <= entry_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.fwd_sel     = fwd_sel;
  assign bus.fwd_mem     = fwd_mem;
  assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Bench for fwd_hazard_scoreboard: two configurations driven with identical
// stimulus, expectations from a behavioural model queued per cycle.
module tb_fwd_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fwd_hazard_scoreboard_if #(.NUM_SRC(2), .DEPTH(2), .CNT_W(4))  ifa ();
  fwd_hazard_scoreboard_if #(.NUM_SRC(2), .DEPTH(3), .CNT_W(32)) ifb ();

  fwd_hazard_scoreboard #(.NUM_SRC(2), .DEPTH(2), .LOAD_LAT(1), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  fwd_hazard_scoreboard #(.NUM_SRC(2), .DEPTH(3), .LOAD_LAT(2), .CNT_W(32)) u_dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  int unsigned cmp_cnt = 0;
  int unsigned err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // stimulus shared by both instances
  logic       s_valid, s_we, s_ld, s_adv, s_flush;
  logic [9:0] s_rs;
  logic [1:0] s_used;
  logic [4:0] s_rd;

  always_comb begin
    ifa.id_valid = s_valid; ifb.id_valid = s_valid;
    ifa.id_rs = s_rs;       ifb.id_rs = s_rs;
    ifa.id_rs_used = s_used; ifb.id_rs_used = s_used;
    ifa.id_rd = s_rd;       ifb.id_rd = s_rd;
    ifa.id_we = s_we;       ifb.id_we = s_we;
    ifa.id_is_load = s_ld;  ifb.id_is_load = s_ld;
    ifa.advance = s_adv;    ifb.advance = s_adv;
    ifa.flush = s_flush;    ifb.flush = s_flush;
  end

  // behavioural model, index [cfg][stage]
  logic        mv  [2][3];
  logic [4:0]  mrd [2][3];
  logic        mwe [2][3];
  logic        mld [2][3];
  logic [31:0] mcnt[2];

  function automatic int dep(input int c);  return (c == 0) ? 2 : 3; endfunction
  function automatic int lat(input int c);  return (c == 0) ? 1 : 2; endfunction
  function automatic logic [31:0] cmax(input int c);
    return (c == 0) ? 32'd15 : 32'hFFFF_FFFF;
  endfunction

  typedef struct {
    logic        stall;
    logic [3:0]  sel;
    logic [1:0]  mem;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[2][$];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 3; k++) begin
        mv[c][k] = 1'b0; mrd[c][k] = '0; mwe[c][k] = 1'b0; mld[c][k] = 1'b0;
      end
      mcnt[c] = '0;
    end
  endtask

  function automatic exp_t model_out(input int c);
    exp_t e;
    e.stall = 1'b0; e.sel = '0; e.mem = '0; e.cnt = mcnt[c];
    for (int i = 0; i < 2; i++) begin
      int w;
      logic [4:0] rs;
      rs = s_rs[5*i +: 5];
      w = -1;
      // scan oldest to youngest so the youngest hit is left standing
      for (int k = dep(c) - 1; k >= 0; k--)
        if (s_valid && s_used[i] && rs != 5'd0 && mv[c][k] && mwe[c][k] && mrd[c][k] == rs)
          w = k;
      if (w >= 0) begin
        if (mld[c][w] && w < lat(c)) e.stall = 1'b1;
        else begin
          e.sel[2*i +: 2] = 2'(w + 1);
          e.mem[i] = mld[c][w];
        end
      end
    end
    return e;
  endfunction

  task automatic model_step(input int c, input logic st);
    if (st && mcnt[c] != cmax(c)) mcnt[c] = mcnt[c] + 1;
    if (s_flush) begin
      for (int k = 0; k < 3; k++) mv[c][k] = 1'b0;
    end else if (s_adv) begin
      for (int k = dep(c) - 1; k >= 1; k--) begin
        mv[c][k] = mv[c][k-1]; mrd[c][k] = mrd[c][k-1];
        mwe[c][k] = mwe[c][k-1]; mld[c][k] = mld[c][k-1];
      end
      mv[c][0]  = s_valid && !st;
      mrd[c][0] = s_rd;
      mwe[c][0] = s_we && (s_rd != 5'd0);
      mld[c][0] = s_ld;
    end
  endtask

  // Called at posedge+1 with stimulus already set; returns at the next posedge+1.
  task automatic cycle();
    exp_t ea, eb;
    sb[0].push_back(model_out(0));
    sb[1].push_back(model_out(1));
    #3;
    ea = sb[0].pop_front();
    eb = sb[1].pop_front();
    check("a.stall", {31'd0, ifa.stall}, {31'd0, ea.stall});
    check("a.sel",   {28'd0, ifa.fwd_sel}, {28'd0, ea.sel});
    check("a.mem",   {30'd0, ifa.fwd_mem}, {30'd0, ea.mem});
    check("a.cnt",   {28'd0, ifa.stall_count}, ea.cnt);
    check("b.stall", {31'd0, ifb.stall}, {31'd0, eb.stall});
    check("b.sel",   {28'd0, ifb.fwd_sel}, {28'd0, eb.sel});
    check("b.mem",   {30'd0, ifb.fwd_mem}, {30'd0, eb.mem});
    check("b.cnt",   ifb.stall_count, eb.cnt);
    model_step(0, ea.stall);
    model_step(1, eb.stall);
    @(posedge clk); #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [1:0] used, input logic [4:0] rd,
                        input logic we, input logic ld);
    s_valid = v; s_rs = {rs2, rs1}; s_used = used; s_rd = rd; s_we = we; s_ld = ld;
  endtask

  task automatic idle(input int n);
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    s_adv = 1'b1; s_flush = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    set_id(1'b1, 5'd1, 5'd1, 2'b11, 5'd1, 1'b1, 1'b1);
    s_adv = 1'b1; s_flush = 1'b0;
    model_reset();
    #2;
    check("rst.a.stall", {31'd0, ifa.stall}, 32'd0);
    check("rst.a.sel",   {28'd0, ifa.fwd_sel}, 32'd0);
    check("rst.b.cnt",   ifb.stall_count, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycle();

    // ALU result forwarded from EX/MEM
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0); cycle();
    set_id(1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 1'b0); cycle();
    idle(3);

    // load-use on rs2
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1); cycle();
    set_id(1'b1, 5'd0, 5'd7, 2'b10, 5'd8, 1'b1, 1'b0);
    cycle(); cycle(); cycle();
    check("load.a.cnt", {28'd0, ifa.stall_count}, 32'd1);
    check("load.b.cnt", ifb.stall_count, 32'd2);
    idle(3);

    // back-to-back writers of x3, youngest wins; x0 never forwards
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0); cycle();
    set_id(1'b1, 5'd3, 5'd0, 2'b01, 5'd3, 1'b1, 1'b0); cycle();
    set_id(1'b1, 5'd3, 5'd3, 2'b11, 5'd0, 1'b1, 1'b0); cycle();
    set_id(1'b1, 5'd0, 5'd0, 2'b11, 5'd10, 1'b0, 1'b0); cycle();
    idle(3);

    // flush with a load-dependent instruction in ID
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1); cycle();
    set_id(1'b1, 5'd9, 5'd0, 2'b01, 5'd12, 1'b1, 1'b0); s_flush = 1'b1; cycle();
    s_flush = 1'b0; cycle();
    idle(3);

    // hazard held with no advance: counter must saturate in the 4-bit instance
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd11, 1'b1, 1'b1); cycle();
    set_id(1'b1, 5'd11, 5'd0, 2'b01, 5'd13, 1'b1, 1'b0); s_adv = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    check("sat.a.cnt", {28'd0, ifa.stall_count}, 32'd15);
    s_adv = 1'b1; cycle(); cycle(); cycle();
    idle(3);

    // reset asserted in the middle of a stall
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b1); cycle();
    set_id(1'b1, 5'd4, 5'd0, 2'b01, 5'd14, 1'b1, 1'b0); cycle();
    check("pre.b.stall", {31'd0, ifb.stall}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid.a.stall", {31'd0, ifa.stall}, 32'd0);
    check("mid.b.stall", {31'd0, ifb.stall}, 32'd0);
    check("mid.b.cnt",   ifb.stall_count, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    cycle();
    idle(2);

    // random traffic on a small register set
    for (int n = 0; n < 300; n++) begin
      set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      s_adv   = 1'($urandom_range(0, 4) != 0);
      s_flush = 1'($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
